// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the 4x4 shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH  = 4;
  localparam int PROD_W = 2 * WIDTH;
  localparam int STEPS  = 4;
  localparam int CNT_W  = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder_4b.sv
// 4-bit ripple-carry adder: sum/cout from a + b + cin, purely combinational.
module fulladder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic carry;

  // Carry ripples through a procedural variable to keep the chain acyclic.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mult_4b.sv
// Sequential 4x4 unsigned multiplier: one adder pass per cycle, start/done handshake.
module shift_add_mult_4b
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   a_q;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;
  logic               done_q;
  logic [PROD_W-1:0]  product_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   s_nxt;
  logic               c_nxt;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   q_d;

  assign addend = q_q[0] ? m_q : '0;

  fulladder_4b u_add (
    .a    (a_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (s_nxt),
    .cout (c_nxt)
  );

  // Right shift of {C,A,Q}: the adder carry lands directly in A's MSB, so C
  // is always zero after the shift and needs no storage of its own.
  assign a_d = {c_nxt, s_nxt[WIDTH-1:1]};
  assign q_d = {s_nxt[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            a_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q     <= a_d;
          q_q     <= q_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            product_q <= {a_d, q_d};
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_4b.sv
// Randomized scoreboard bench for shift_add_mult_4b against an a*b reference.
module tb_shift_add_mult_4b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_prod[$];
  int unsigned exp_due[$];

  shift_add_mult_4b dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected result and the cycle on which done must be seen.
  task automatic expect_result(input logic [3:0] x, input logic [3:0] y);
    exp_prod.push_back({4'b0, x} * {4'b0, y});
    exp_due.push_back(cyc + 5);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : monitor
    logic [7:0]  p;
    int unsigned d;
    if (done) begin
      if (exp_prod.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=1 product=%0d at cycle %0d, required no done", product, cyc);
      end else begin
        p = exp_prod.pop_front();
        d = exp_due.pop_front();
        check("product", int'(product), int'(p));
        check("latency", int'(cyc), int'(d));
        $display("txn: product=%0d expected=%0d at cycle %0d", product, p, cyc);
      end
    end
  end

  // junk: 0 = start low during CALC, 1 = random start/operands, 2 = start with a=1,b=1
  task automatic send(input logic [3:0] x, input logic [3:0] y, input int junk);
    a = x;
    b = y;
    start = 1'b1;
    expect_result(x, y);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (junk == 1) begin
        start = 1'($urandom_range(0, 1));
        a = 4'($urandom);
        b = 4'($urandom);
      end else if (junk == 2) begin
        start = 1'b1;
        a = 4'd1;
        b = 4'd1;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3*5 with busy/done profile checked cycle by cycle
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    expect_result(4'd3, 4'd5);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("busy_calc", int'(busy), 1);
      @(negedge clk);
    end
    check("busy_done", int'(busy), 0);
    check("done_pulse", int'(done), 1);
    @(negedge clk);
    check("done_single", int'(done), 0);

    send(4'd15, 4'd15, 0);
    send(4'd0, 4'd9, 0);
    send(4'd9, 4'd0, 0);
    send(4'd7, 4'd6, 2);
    @(negedge clk);

    // start held high through DONE: 2*3 then 4*4 back-to-back
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    expect_result(4'd2, 4'd3);
    repeat (5) @(negedge clk);
    a = 4'd4;
    b = 4'd4;
    expect_result(4'd4, 4'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // reset during the second CALC cycle of 12*11 abandons the operation
    a = 4'd12;
    b = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_product", int'(product), 0);
    repeat (8) @(negedge clk);

    repeat (200) begin
      send(4'($urandom), 4'($urandom), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (8) @(negedge clk);
    check("drain_pending", exp_prod.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
